// File: rtl/exec_pkg.sv
// Shared function codes and multiplier state encoding for the EX-stage execute unit.
package exec_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mstate_e;

endpackage

// File: rtl/exec_unit_param_seq_mult.sv
// Iterative radix-2 shift-add multiplier; signed operands are handled as
// magnitudes with the product sign applied at the end.
module seq_mult
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  mstate_e            state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     step_sum;

  // Most-negative magnitude keeps its bit pattern, which is the correct unsigned value.
  assign a_abs    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs    = (is_signed && b[WIDTH-1]) ? -b : b;
  assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a_abs;
            acc_q   <= {{WIDTH{1'b0}}, b_abs};
            neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= {step_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/exec_unit_param.sv
// Handshaked EX-stage execute unit: single-cycle ALU/shifter, HI/LO registers and
// an interlocked iterative multiplier.
module exec_unit_param
  import exec_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             mult_busy,
  output logic             mult_done
);

  logic [WIDTH-1:0]   hi_q, lo_q, result_q;
  logic               out_valid_q, illegal_q, mult_done_q;
  logic [WIDTH-1:0]   res_d;
  logic               legal_d;
  logic               is_mul, is_mf, accept;
  logic               m_busy, m_done;
  logic [2*WIDTH-1:0] m_product;
  logic [SHW-1:0]     shamt;

  assign is_mul   = (funct == F_MULT) || (funct == F_MULTU);
  assign is_mf    = (funct == F_MFHI) || (funct == F_MFLO);
  assign in_ready = !(m_busy && (is_mul || is_mf));
  assign accept   = in_valid && in_ready;
  assign shamt    = dataA[SHW-1:0];

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_mul),
    .is_signed (funct == F_MULT),
    .a         (dataA),
    .b         (dataB),
    .busy      (m_busy),
    .done      (m_done),
    .product   (m_product)
  );

  always_comb begin
    res_d   = '0;
    legal_d = 1'b1;
    case (funct)
      F_AND:   res_d = dataA & dataB;
      F_OR:    res_d = dataA | dataB;
      F_ADD:   res_d = dataA + dataB;
      F_SUB:   res_d = dataA - dataB;
      F_SLT:   res_d = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};
      F_SLTU:  res_d = {{(WIDTH-1){1'b0}}, dataA < dataB};
      F_SLL:   res_d = dataB << shamt;
      F_SRL:   res_d = dataB >> shamt;
      F_SRA:   res_d = $unsigned($signed(dataB) >>> shamt);
      F_MFHI:  res_d = hi_q;
      F_MFLO:  res_d = lo_q;
      F_MULT, F_MULTU: res_d = '0;
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      mult_done_q <= 1'b0;
    end else begin
      // The multiplier's DONE cycle commits HI/LO; mult_done marks the first cycle they are visible.
      mult_done_q <= m_done;
      if (m_done) begin
        {hi_q, lo_q} <= m_product;
      end
      if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= res_d;
        illegal_q   <= !legal_d;
      end else begin
        out_valid_q <= 1'b0;
        illegal_q   <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign mult_busy = m_busy;
  assign mult_done = mult_done_q;

endmodule

// File: tb/tb_exec_unit_param.sv
// Directed self-checking bench for exec_unit_param at WIDTH=32 and WIDTH=16.
module tb_exec_unit_param;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        in_valid, in_ready, out_valid, illegal, mult_busy, mult_done;
  logic [5:0]  funct;
  logic [31:0] dataA, dataB, result;

  logic        h_in_valid, h_in_ready, h_out_valid, h_illegal, h_mult_busy, h_mult_done;
  logic [5:0]  h_funct;
  logic [15:0] h_dataA, h_dataB, h_result;

  int errs = 0;
  int checks = 0;
  int k;

  always #5 clk = ~clk;

  exec_unit_param #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .result(result), .illegal(illegal),
    .mult_busy(mult_busy), .mult_done(mult_done)
  );

  exec_unit_param #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .funct(h_funct),
    .dataA(h_dataA), .dataB(h_dataB), .out_valid(h_out_valid), .result(h_result),
    .illegal(h_illegal), .mult_busy(h_mult_busy), .mult_done(h_mult_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    funct = f; dataA = a; dataB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic op16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b);
    h_funct = f; h_dataA = a; h_dataB = b; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
  endtask

  // Cycles until mult_done is seen; 41 means it never came within the budget.
  task automatic wait_done(input bit narrow, output int cyc);
    cyc = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (narrow ? h_mult_done : mult_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0; funct = F_AND; dataA = '0; dataB = '0;
    h_in_valid = 1'b0; h_funct = F_AND; h_dataA = '0; h_dataB = '0;

    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", mult_busy, 0);
    chk("rst_done", mult_done, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;

    op(F_ADD, 32'hFFFF_FFFF, 32'h1);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 32'h0);
    chk("add_illegal", illegal, 0);
    @(posedge clk); #1;
    chk("valid_drop", out_valid, 0);
    op(F_SLT, 32'hFFFF_FFFF, 32'h1);   chk("slt", result, 32'h1);
    op(F_SLTU, 32'hFFFF_FFFF, 32'h1);  chk("sltu", result, 32'h0);
    op(F_SUB, 32'd5, 32'd7);           chk("sub", result, 32'hFFFF_FFFE);
    op(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); chk("and", result, 32'hF000_F000);
    op(F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);  chk("or", result, 32'hFFF0_FFF0);

    op(F_SRL, 32'h24, 32'h8000_0010); chk("srl", result, 32'h0800_0001);
    op(F_SRA, 32'h24, 32'h8000_0010); chk("sra", result, 32'hF800_0001);
    op(F_SLL, 32'h24, 32'h8000_0010); chk("sll", result, 32'h0000_0100);
    op(F_SRA, 32'h20, 32'h8000_0010); chk("sra_amt0", result, 32'h8000_0010);

    op(6'd63, 32'h1234, 32'h5678);
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_result", result, 32'h0);

    op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy", mult_busy, 1);
    chk("mult_no_valid", out_valid, 0);
    wait_done(1'b0, k);
    chk("mult_latency", k, 33);
    chk("mult_busy_fall", mult_busy, 0);
    op(F_MFLO, 0, 0); chk("mult_lo", result, 32'hFFFF_FFEB);
    op(F_MFHI, 0, 0); chk("mult_hi", result, 32'hFFFF_FFFF);

    op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    funct = F_MFHI; in_valid = 1'b1;
    chk("lock_ready0", in_ready, 0);
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (in_ready) begin
        k = i;
        break;
      end
      if (out_valid) chk("lock_early_accept", out_valid, 0);
    end
    chk("lock_release", k, 33);
    chk("lock_done_same", mult_done, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lock_mfhi_valid", out_valid, 1);
    chk("lock_mfhi", result, 32'hFFFF_FFFE);
    op(F_MFLO, 0, 0); chk("lock_mflo", result, 32'h0000_0001);

    op(F_MULT, 32'd6, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    op(F_ADD, 32'd5, 32'd6);
    chk("ovl_valid", out_valid, 1);
    chk("ovl_add", result, 32'd11);
    chk("ovl_busy", mult_busy, 1);
    wait_done(1'b0, k);
    chk("ovl_latency", k, 30);
    op(F_MFLO, 0, 0); chk("ovl_lo", result, 32'd42);
    op(F_MFHI, 0, 0); chk("ovl_hi", result, 32'd0);

    op(F_MULT, 32'd2, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("abort_busy", mult_busy, 0);
    chk("abort_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_done(1'b0, k);
    chk("abort_no_done", k, 41);
    op(F_MFLO, 0, 0); chk("abort_lo", result, 32'd0);
    op(F_MFHI, 0, 0); chk("abort_hi", result, 32'd0);

    op16(F_MULT, 16'h8000, 16'hFFFF);
    wait_done(1'b1, k);
    chk("w16_latency", k, 17);
    op16(F_MFHI, 0, 0); chk("w16_hi", h_result, 16'h0000);
    op16(F_MFLO, 0, 0); chk("w16_lo", h_result, 16'h8000);
    op16(F_SRA, 16'h0013, 16'h8000); chk("w16_sra", h_result, 16'hF000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/exec_unit_param.md
Name: exec_unit_param

Overview:
- Parametrised, handshaked integer execute unit for the pipelined CPU's EX stage; next generation of the fixed 32-bit ALU/multiplier/HI-LO/shifter cluster.
- Generalised in data width.
- Adds over the previous block:
  - valid/ready handshake with decoder stall;
  - signed and unsigned iterative multiply;
  - left, logical-right and arithmetic-right shifts;
  - SLTU;
  - MFHI/MFLO interlock against an in-flight multiply;
  - illegal-function flag.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit accepts the presented operation this cycle.
- funct  input  6  MIPS R-type function code.
- dataA  input  WIDTH  rs operand; also the shift amount source.
- dataB  input  WIDTH  rt operand; also the value being shifted.
- out_valid  output  1  result valid, one-cycle pulse.
- result  output  WIDTH  registered result.
- illegal  output  1  qualifies out_valid: funct was unsupported.
- mult_busy  output  1  multiply in progress.
- mult_done  output  1  one-cycle pulse; HI/LO updated this cycle.

Behaviour:
- Function codes:
  - AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLTU 43.
  - SLL 0, SRL 2, SRA 3.
  - MULT 24, MULTU 25, MFHI 16, MFLO 18.
- Reset (reset=0, asynchronous):
  - out_valid=0, result=0, illegal=0, mult_busy=0, mult_done=0.
  - HI=0, LO=0, multiplier FSM to IDLE.
  - Reset asserted mid-multiply aborts it; HI/LO are not written.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge.
- in_ready:
  - 0 while mult_busy and funct is MULT, MULTU, MFHI or MFLO;
  - 1 otherwise, including ALU/shift ops during a multiply.
  - in_ready may depend combinationally on funct.
- Single-cycle ops (ALU, shift, MF*, illegal):
  - out_valid=1 and result updated on the edge after accept; latency 1.
  - out_valid deasserts the next cycle unless another op is accepted.
- Arithmetic:
  - ADD/SUB: modulo 2^WIDTH; no overflow trap.
  - SLT: signed compare; SLTU: unsigned compare; result 1 or 0, zero-extended.
- Shifts:
  - amount = dataA[SHW-1:0]; upper bits are ignored.
  - Shifted value is dataB.
  - SRA replicates dataB[WIDTH-1]; amount 0 returns dataB.
- MFHI/MFLO: return the current HI/LO.
  - Never accepted while busy, so the interlock guarantees post-multiply values.
  - A MF* accepted in the same cycle mult_done is high sees the new HI/LO.
- Multiply: no out_valid.
  - FSM IDLE -> RUN -> DONE -> IDLE.
  - Accept of MULT/MULTU in IDLE:
    - latch operands (MULT: absolute values plus sign flag) and set counter=0;
    - mult_busy=1 from the next edge.
  - RUN: one radix-2 shift-add step per cycle for WIDTH cycles.
  - DONE (one cycle):
    - HI:LO <= 2*WIDTH-bit product, negated if the sign flag is set;
    - mult_done=1.
  - Back to IDLE the following cycle; mult_busy falls with the return to IDLE.
  - Total: mult_done is high WIDTH+1 cycles after the accept edge.
  - MULT of the most-negative value by -1 yields the exact 2*WIDTH-bit product; no overflow.
- Illegal funct:
  - result=0, illegal=1 alongside out_valid;
  - HI/LO and the FSM are unaffected.
- Simultaneous events: an ALU op accepted in the DONE cycle completes normally; its out_valid coincides with IDLE.
- Internal state: none besides HI/LO, the FSM and operand/accumulator registers.

Decomposition:
- Package exec_pkg holds:
  - funct localparams (F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_MULT, F_MULTU, F_MFHI, F_MFLO);
  - the multiplier state encoding (IDLE, RUN, DONE).
- One sub-module, seq_mult, parametrised by WIDTH:
  - ports: start, is_signed, a, b, busy, done, product[2*WIDTH-1:0];
  - it owns the FSM and sign handling.
- The ALU, shifter, HI/LO registers and the handshake stay in the top module.

Test Plan:
- Reset/ALU: hold reset=0 for 3 cycles, release, then ADD 0xFFFFFFFF+1 -> next cycle out_valid=1, result=0x00000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU of the same operands -> 0.
- Shifts: dataB=0x80000010, dataA=0x24 (amount 4) -> SRL 0x08000001, SRA 0xF8000001, SLL 0x00000100.
- Signed multiply: MULT -3 x 7 -> mult_done exactly 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO then returns 0xFFFFFFEB.
- Interlock: MULTU 0xFFFFFFFF x 0xFFFFFFFF, then MFHI held with in_valid=1 -> in_ready=0 until the mult_done cycle; MFHI result=0xFFFFFFFE, MFLO=0x00000001.
- Overlap and abort:
  - ADD 5+6 during a multiply -> result 11 after 1 cycle, multiply unaffected;
  - reset pulsed at cycle 10 of a MULT -> mult_busy=0 immediately, HI/LO=0, no mult_done.
- Illegal/WIDTH: funct 63 -> out_valid=1, illegal=1, result=0; with WIDTH=16, MULT 0x8000 x 0xFFFF -> HI=0x0000, LO=0x8000 after 17 cycles.
